p3ctrl_n: RTL
=============

Name: p3ctrl_n

Overview:
- Parametrised successor to the three-buffer ping/pang/pong controller.
- Manages N_BUFS packet buffers circulating between three agents: A = snooper (fills), B = CPU/filter (accepts or rejects), C = forwarder (drains).
- Holds one token FIFO per agent and runs a start/done handshake per agent.
- Emits the buffer index each agent owns, plus a per-buffer owner code that drives the buffer muxes inside packetfilter_core.

Parameters:
- N_BUFS, 3, number of packet buffers; legal range 2..16.
- TOK_W, $clog2(N_BUFS) (minimum 1), token/index width; derived, not overridden.
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- rdy_for_A  out  1  A may start on sn_sel.
- rdy_for_A_ack  in  1  A starts; sampled with rdy_for_A.
- A_done  in  1  A finished its buffer.
- A_done_ack  out  1  controller accepts A_done.
- rdy_for_B, rdy_for_B_ack, B_acc, B_rej, B_done_ack  same roles for B; B_acc/B_rej mutually exclusive.
- rdy_for_C, rdy_for_C_ack, C_done, C_done_ack  same roles for C.
- sn_sel, cpu_sel, fwd_sel  out  TOK_W each  head token of each queue.
- sn_vld, cpu_vld, fwd_vld  out  1 each  agent currently owns its head buffer (busy).
- buf_owner  out  2*N_BUFS  per buffer i, bits [2i+1:2i]: 00 unowned, 01 A, 10 B, 11 C.
- sn_cnt, cpu_cnt, fwd_cnt  out  TOK_W+1 each  queue occupancy.

Behaviour:
- Reset values (asserted asynchronously; released to the clock edge):
  - sn queue holds 0,1,..,N_BUFS-1 with head 0; sn_cnt=N_BUFS; cpu_cnt=fwd_cnt=0.
  - All busy flags clear; all sel=0; all vld=0.
  - buf_owner all 00; rdy_for_A=1 on the first cycle after reset release; rdy_for_B=rdy_for_C=0.
- Per agent X, with queue Q:
  - rdy_for_X = (Q count>0) && !busy_X.
  - Start event = rdy_for_X && rdy_for_X_ack; it sets busy_X on the next edge. An ack while rdy is low is ignored.
  - X_done_ack = busy_X, combinational.
  - Done event = done && X_done_ack. It pops Q's head, pushes that token into the successor queue, and clears busy_X, all at the same edge.
  - done while !busy_X is ignored, with no state change.
- Routing:
  - A_done pushes to the cpu queue.
  - B_acc pushes to the fwd queue.
  - B_rej pushes to the sn queue.
  - C_done pushes to the sn queue.
- Simultaneous events:
  - Any combination of the three done events in one cycle is legal.
  - The sn queue accepts two pushes in one cycle (B_rej and C_done). B's token is written first, C's token second.
  - A push and a pop on the same queue in one cycle: count is unchanged, order is preserved.
  - A start and a done on the same agent cannot coincide, because rdy requires !busy.
- Boundaries:
  - Total tokens is invariant at N_BUFS, so no queue overflows.
  - A queue is implemented as an N_BUFS-entry circular buffer with TOK_W-bit pointers, wrapping at N_BUFS-1 back to 0 (modulo N_BUFS, not 2^TOK_W).
  - Popping an empty queue is impossible, since busy implies count>0.
  - B_acc and B_rej asserted together is illegal: treat as B_rej and flag in assertion builds.
- Select timing:
  - X_sel is the registered head token; it is stable while busy_X.
  - X_vld = busy_X.
  - buf_owner is combinational from sel/vld. A token not at a busy head reads 00.
- Reset mid-operation: all queues, busy flags and counters return to reset values immediately; in-flight handshakes are dropped.
- Latency: a done event makes the successor's rdy visible one cycle later.

Optional Feature:
- Macro P3CTRL_STATS_EN.
- Defined:
  - Adds outputs acc_count, rej_count, fwd_count (each STAT_W), counting B_acc, B_rej and C_done events respectively.
  - Each counter saturates at all-ones.
  - Counters clear on reset and on input stats_clr (1 bit, synchronous; clear wins over a same-cycle increment).
- Undefined: those ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with N_BUFS=3 -> sn_cnt=3, sn_sel=0, rdy_for_A=1, rdy_for_B=0, buf_owner=000000.
- A start, A_done; B start, B_acc; C start, C_done -> token 0 reaches the sn queue tail; sn_sel sequence 0,1,2,0; fwd_cnt returns to 0.
- A start, A_done; B start, B_rej -> token 0 returns to sn; cpu_cnt=0; fwd_cnt=0; rej_count=1 if stats enabled.
- Same-cycle B_rej (token 1) and C_done (token 0) with sn queue holding {2} -> sn_cnt=3, pop order 2,1,0.
- N_BUFS=5: cycle every token through accept 7 times -> pointer wrap correct; token order 0..4 repeats; no duplicate or lost token (sum of counts stays 5).
- Reset pulse while A and B busy -> outputs return to reset values asynchronously; no spurious rdy_for_C afterwards.

Source files
------------

// File: rtl/p3ctrl_n_if.sv
// rtl/p3ctrl_n_if.sv - agent handshake, select, owner and occupancy bundle for p3ctrl_n
interface p3ctrl_n_if #(
    parameter int N_BUFS = 3
);
    localparam int TOK_W = (N_BUFS > 1) ? $clog2(N_BUFS) : 1;

    logic                  rdy_for_A;
    logic                  rdy_for_A_ack;
    logic                  A_done;
    logic                  A_done_ack;
    logic                  rdy_for_B;
    logic                  rdy_for_B_ack;
    logic                  B_acc;
    logic                  B_rej;
    logic                  B_done_ack;
    logic                  rdy_for_C;
    logic                  rdy_for_C_ack;
    logic                  C_done;
    logic                  C_done_ack;
    logic [TOK_W-1:0]      sn_sel;
    logic [TOK_W-1:0]      cpu_sel;
    logic [TOK_W-1:0]      fwd_sel;
    logic                  sn_vld;
    logic                  cpu_vld;
    logic                  fwd_vld;
    logic [2*N_BUFS-1:0]   buf_owner;
    logic [TOK_W:0]        sn_cnt;
    logic [TOK_W:0]        cpu_cnt;
    logic [TOK_W:0]        fwd_cnt;

    modport master (
        input  rdy_for_A, A_done_ack, rdy_for_B, B_done_ack, rdy_for_C, C_done_ack,
        input  sn_sel, cpu_sel, fwd_sel, sn_vld, cpu_vld, fwd_vld, buf_owner,
        input  sn_cnt, cpu_cnt, fwd_cnt,
        output rdy_for_A_ack, A_done, rdy_for_B_ack, B_acc, B_rej, rdy_for_C_ack, C_done
    );

    modport slave (
        output rdy_for_A, A_done_ack, rdy_for_B, B_done_ack, rdy_for_C, C_done_ack,
        output sn_sel, cpu_sel, fwd_sel, sn_vld, cpu_vld, fwd_vld, buf_owner,
        output sn_cnt, cpu_cnt, fwd_cnt,
        input  rdy_for_A_ack, A_done, rdy_for_B_ack, B_acc, B_rej, rdy_for_C_ack, C_done
    );
endinterface

// File: rtl/p3ctrl_n.sv
// rtl/p3ctrl_n.sv - N-buffer snooper/cpu/forwarder token controller; optional statistics via P3CTRL_STATS_EN
module p3ctrl_n #(
    parameter int N_BUFS = 3,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef P3CTRL_STATS_EN
    input  logic              stats_clr,
    output logic [STAT_W-1:0] acc_count,
    output logic [STAT_W-1:0] rej_count,
    output logic [STAT_W-1:0] fwd_count,
`endif
    p3ctrl_n_if.slave         bus
);
    localparam int TOK_W = (N_BUFS > 1) ? $clog2(N_BUFS) : 1;
    localparam int CW    = TOK_W + 1;
    // queue / agent index: 0 = sn (A), 1 = cpu (B), 2 = fwd (C)
    localparam int QSN   = 0;
    localparam int QCPU  = 1;
    localparam int QFWD  = 2;

    typedef logic [TOK_W-1:0] tok_t;
    typedef logic [CW-1:0]    cnt_t;

    tok_t       q_mem  [3][N_BUFS];
    tok_t       q_head [3];
    tok_t       q_tail [3];
    tok_t       q_sel  [3];
    cnt_t       q_cnt  [3];
    logic [2:0] busy;

    tok_t       n_mem  [3][N_BUFS];
    tok_t       n_head [3];
    tok_t       n_tail [3];
    tok_t       n_sel  [3];
    cnt_t       n_cnt  [3];

    logic [2:0] rdy;
    logic [2:0] start;
    logic [2:0] done;
    logic [2:0] push0;
    logic [2:0] push1;
    tok_t       push0_tok [3];
    tok_t       push1_tok [3];
    logic       b_acc_eff;

    // Pointers wrap at N_BUFS-1, not at the power of two above it.
    function automatic tok_t ptr_inc(input tok_t p);
        return (p == tok_t'(N_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake events and queue routing; a done pops the agent's own queue.
    always_comb begin
        for (int q = 0; q < 3; q++) begin
            rdy[q] = (q_cnt[q] != '0) && !busy[q];
        end
        start     = rdy & {bus.rdy_for_C_ack, bus.rdy_for_B_ack, bus.rdy_for_A_ack};
        done      = busy & {bus.C_done, bus.B_acc | bus.B_rej, bus.A_done};
        b_acc_eff = bus.B_acc && !bus.B_rej;
        push0[QSN]      = done[QCPU] && bus.B_rej;
        push0[QCPU]     = done[QSN];
        push0[QFWD]     = done[QCPU] && b_acc_eff;
        push0_tok[QSN]  = q_sel[QCPU];
        push0_tok[QCPU] = q_sel[QSN];
        push0_tok[QFWD] = q_sel[QCPU];
        // second sn write port: C's token lands behind B's rejected one
        push1           = {2'b00, done[QFWD]};
        push1_tok[QSN]  = q_sel[QFWD];
        push1_tok[QCPU] = '0;
        push1_tok[QFWD] = '0;
    end

    // Next queue state; the select register takes the post-update head entry.
    always_comb begin
        n_mem  = q_mem;
        n_head = q_head;
        n_tail = q_tail;
        for (int q = 0; q < 3; q++) begin
            if (push0[q]) begin
                n_mem[q][n_tail[q]] = push0_tok[q];
                n_tail[q]           = ptr_inc(n_tail[q]);
            end
            if (push1[q]) begin
                n_mem[q][n_tail[q]] = push1_tok[q];
                n_tail[q]           = ptr_inc(n_tail[q]);
            end
            if (done[q]) begin
                n_head[q] = ptr_inc(q_head[q]);
            end
            n_cnt[q] = q_cnt[q] + cnt_t'(push0[q]) + cnt_t'(push1[q]) - cnt_t'(done[q]);
            n_sel[q] = n_mem[q][n_head[q]];
        end
    end

    // Queue, select and busy registers; sn starts full with tokens in index order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < 3; q++) begin
                for (int i = 0; i < N_BUFS; i++) begin
                    q_mem[q][i] <= (q == QSN) ? tok_t'(i) : '0;
                end
                q_head[q] <= '0;
                q_tail[q] <= '0;
                q_sel[q]  <= '0;
                q_cnt[q]  <= (q == QSN) ? cnt_t'(N_BUFS) : '0;
            end
            busy <= '0;
        end else begin
            q_mem  <= n_mem;
            q_head <= n_head;
            q_tail <= n_tail;
            q_sel  <= n_sel;
            q_cnt  <= n_cnt;
            busy   <= (busy | start) & ~done;
        end
    end

    assign bus.rdy_for_A  = rdy[QSN];
    assign bus.rdy_for_B  = rdy[QCPU];
    assign bus.rdy_for_C  = rdy[QFWD];
    assign bus.A_done_ack = busy[QSN];
    assign bus.B_done_ack = busy[QCPU];
    assign bus.C_done_ack = busy[QFWD];
    assign bus.sn_vld     = busy[QSN];
    assign bus.cpu_vld    = busy[QCPU];
    assign bus.fwd_vld    = busy[QFWD];
    assign bus.sn_sel     = q_sel[QSN];
    assign bus.cpu_sel    = q_sel[QCPU];
    assign bus.fwd_sel    = q_sel[QFWD];
    assign bus.sn_cnt     = q_cnt[QSN];
    assign bus.cpu_cnt    = q_cnt[QCPU];
    assign bus.fwd_cnt    = q_cnt[QFWD];

    // Owner code per buffer: only a busy agent's head token is marked.
    always_comb begin
        bus.buf_owner = '0;
        for (int i = 0; i < N_BUFS; i++) begin
            if (busy[QSN] && q_sel[QSN] == tok_t'(i)) begin
                bus.buf_owner[2*i +: 2] = 2'b01;
            end else if (busy[QCPU] && q_sel[QCPU] == tok_t'(i)) begin
                bus.buf_owner[2*i +: 2] = 2'b10;
            end else if (busy[QFWD] && q_sel[QFWD] == tok_t'(i)) begin
                bus.buf_owner[2*i +: 2] = 2'b11;
            end
        end
    end

`ifndef SYNTHESIS
    // Accept and reject together is resolved as reject, but never expected.
    a_b_exclusive: assert property (@(posedge clk) disable iff (!rst) !(bus.B_acc && bus.B_rej));
`endif

`ifdef P3CTRL_STATS_EN
    logic [STAT_W-1:0] acc_q;
    logic [STAT_W-1:0] rej_q;
    logic [STAT_W-1:0] fwdc_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

    // Saturating event counters; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            rej_q  <= '0;
            fwdc_q <= '0;
        end else if (stats_clr) begin
            acc_q  <= '0;
            rej_q  <= '0;
            fwdc_q <= '0;
        end else begin
            acc_q  <= sat_inc(acc_q, done[QCPU] && b_acc_eff);
            rej_q  <= sat_inc(rej_q, done[QCPU] && bus.B_rej);
            fwdc_q <= sat_inc(fwdc_q, done[QFWD]);
        end
    end

    assign acc_count = acc_q;
    assign rej_count = rej_q;
    assign fwd_count = fwdc_q;
`endif
endmodule
